// File: rtl/spi_receiver_if.sv
// Consumer-side bus of the SPI receiver: received byte, valid/ack handshake and status flags.
interface spi_receiver_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  data_hazir;
  logic                  data_al;
  logic                  overrun;
  logic                  frame_error;
  logic [7:0]            byte_count;

  modport master (
    output rx_data, data_hazir, overrun, frame_error, byte_count,
    input  data_al
  );

  modport slave (
    input  rx_data, data_hazir, overrun, frame_error, byte_count,
    output data_al
  );
endinterface

// File: rtl/spi_receiver.sv
// SPI slave receiver (CPOL=0/CPHA=0, MSB first): oversamples the SPI pins, shifts bytes in, and
// presents each byte with a valid/ack handshake; data_hazir rises SYNC_STAGES+1 clk after the last pin edge.
module spi_receiver #(
  parameter int SYNC_STAGES = 2,
  parameter int DATA_WIDTH  = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            spi_clk,
  input  logic            spi_ce,
  input  logic            spi_data_in,
  spi_receiver_if.master  rx
);
  localparam int            CW   = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  typedef enum logic {IDLE, RECEIVE} state_t;

  logic [SYNC_STAGES-1:0] clk_sync, ce_sync, din_sync, flush;
  logic                   s_clk, s_ce, s_din, s_clk_d, rise;
  logic                   armed, flushed;
  state_t                 state, state_nxt;
  logic [CW-1:0]          cnt;
  logic [DATA_WIDTH-1:0]  shift, new_byte;
  logic                   do_shift, byte_done, ferr_nxt;

  assign s_clk    = clk_sync[SYNC_STAGES-1];
  assign s_ce     = ce_sync[SYNC_STAGES-1];
  assign s_din    = din_sync[SYNC_STAGES-1];
  assign rise     = s_clk & ~s_clk_d;
  assign flushed  = flush[SYNC_STAGES-1];
  assign new_byte = {shift[DATA_WIDTH-2:0], s_din};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_sync <= '0;
      ce_sync  <= '1;
      din_sync <= '0;
      s_clk_d  <= 1'b0;
      flush    <= '0;
      armed    <= 1'b0;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], spi_clk};
      ce_sync  <= {ce_sync[SYNC_STAGES-2:0], spi_ce};
      din_sync <= {din_sync[SYNC_STAGES-2:0], spi_data_in};
      s_clk_d  <= s_clk;
      flush    <= {flush[SYNC_STAGES-2:0], 1'b1};
      // Only a chip-enable seen high after the synchronizers have flushed arms the receiver,
      // so a reset released mid-frame cannot pick up the tail of that frame.
      armed    <= armed | (flushed & s_ce);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    do_shift  = 1'b0;
    ferr_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (armed && !s_ce) begin
          state_nxt = RECEIVE;
          do_shift  = rise;
        end
      end
      RECEIVE: begin
        if (s_ce) begin
          state_nxt = IDLE;
          ferr_nxt  = (cnt != '0);
        end else begin
          do_shift  = rise;
        end
      end
      default: state_nxt = IDLE;
    endcase
    byte_done = do_shift && (cnt == LAST);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt   <= '0;
      shift <= '0;
    end else begin
      if (state_nxt == IDLE)
        cnt <= '0;
      else if (do_shift)
        cnt <= byte_done ? '0 : cnt + 1'b1;
      if (do_shift)
        shift <= new_byte;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx.rx_data     <= '0;
      rx.data_hazir  <= 1'b0;
      rx.overrun     <= 1'b0;
      rx.frame_error <= 1'b0;
      rx.byte_count  <= '0;
    end else begin
      rx.frame_error <= ferr_nxt;
      if (byte_done) begin
        rx.rx_data    <= new_byte;
        rx.data_hazir <= 1'b1;
        rx.byte_count <= rx.byte_count + 8'd1;
        if (rx.data_hazir && !rx.data_al)
          rx.overrun <= 1'b1;
      end else if (rx.data_al) begin
        rx.data_hazir <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_spi_receiver.sv
// Directed SPI frames with a scoreboard: expected bytes are queued at issue and checked on each byte_count step.
module tb_spi_receiver;
  typedef struct packed {
    logic [7:0] data;
    logic       ovr;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic spi_clk = 1'b0;
  logic spi_ce = 1'b1;
  logic spi_data_in = 1'b0;

  int   checks = 0;
  int   errors = 0;
  int   fe_cycles = 0;
  exp_t exp_q[$];

  spi_receiver_if #(.DATA_WIDTH(8)) rx_if ();

  spi_receiver #(.SYNC_STAGES(2), .DATA_WIDTH(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .spi_clk    (spi_clk),
    .spi_ce     (spi_ce),
    .spi_data_in(spi_data_in),
    .rx         (rx_if.master)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    wait_neg(2);
    reset = 1'b1;
    wait_neg(4);
  endtask

  // Shifts out the top n bits of b; each spi_clk half period is 4 clk cycles.
  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      spi_data_in = b[7-i];
      wait_neg(4);
      spi_clk = 1'b1;
      wait_neg(4);
      spi_clk = 1'b0;
    end
  endtask

  // Final bit of a byte; optionally checks completion latency or acks in the completion cycle.
  task automatic send_last(input logic b, input bit ack, input bit lat);
    spi_data_in = b;
    wait_neg(4);
    spi_clk = 1'b1;
    wait_neg(2);
    if (lat) check("latency_not_early", rx_if.data_hazir, 0);
    if (ack) rx_if.data_al = 1'b1;
    wait_neg(1);
    rx_if.data_al = 1'b0;
    if (lat) check("latency_on_time", rx_if.data_hazir, 1);
    wait_neg(1);
    spi_clk = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit ack, input bit lat);
    spi_ce = 1'b0;
    wait_neg(4);
    send_bits(b, 7);
    send_last(b[0], ack, lat);
    wait_neg(4);
    spi_ce = 1'b1;
    wait_neg(8);
  endtask

  task automatic ack();
    rx_if.data_al = 1'b1;
    wait_neg(1);
    rx_if.data_al = 1'b0;
  endtask

  function automatic exp_t mk(input logic [7:0] d, input logic o);
    exp_t e;
    e.data = d;
    e.ovr  = o;
    return e;
  endfunction

  // Monitor: every byte_count step is a completed byte to be matched against the queue.
  initial begin
    logic [7:0] prev_cnt;
    exp_t       e;
    prev_cnt = 8'd0;
    forever begin
      @(negedge clk);
      if (rx_if.frame_error === 1'b1) fe_cycles++;
      if (!reset) begin
        prev_cnt = 8'd0;
      end else if (rx_if.byte_count !== prev_cnt) begin
        check("count_step", rx_if.byte_count, prev_cnt + 8'd1);
        prev_cnt = rx_if.byte_count;
        if (exp_q.size() == 0) begin
          check("unexpected_byte", rx_if.rx_data, 32'hffff_ffff);
        end else begin
          e = exp_q.pop_front();
          check("rx_data", rx_if.rx_data, e.data);
          check("hazir_on_byte", rx_if.data_hazir, 1);
          check("overrun_on_byte", rx_if.overrun, e.ovr);
        end
      end
    end
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    int fe0;
    rx_if.data_al = 1'b0;
    wait_neg(1);
    check("rst_rx_data", rx_if.rx_data, 0);
    check("rst_hazir", rx_if.data_hazir, 0);
    check("rst_overrun", rx_if.overrun, 0);
    check("rst_frame_error", rx_if.frame_error, 0);
    check("rst_byte_count", rx_if.byte_count, 0);
    wait_neg(2);
    reset = 1'b1;
    wait_neg(6);

    // Single frame with latency check.
    exp_q.push_back(mk(8'hA5, 1'b0));
    send_frame(8'hA5, 1'b0, 1'b1);
    check("t1_count", rx_if.byte_count, 1);
    check("t1_overrun", rx_if.overrun, 0);
    check("t1_no_ferr", fe_cycles, 0);
    ack();
    check("t1_ack_clears", rx_if.data_hazir, 0);

    // Back-to-back bytes in one chip-enable window.
    do_reset();
    spi_ce = 1'b0;
    wait_neg(4);
    exp_q.push_back(mk(8'h3C, 1'b0));
    send_bits(8'h3C, 8);
    ack();
    exp_q.push_back(mk(8'hC3, 1'b0));
    send_bits(8'hC3, 8);
    ack();
    wait_neg(4);
    spi_ce = 1'b1;
    wait_neg(8);
    check("t2_count", rx_if.byte_count, 2);
    check("t2_overrun", rx_if.overrun, 0);
    check("t2_rx_last", rx_if.rx_data, 8'hC3);

    // Overrun is sticky across acknowledge.
    do_reset();
    exp_q.push_back(mk(8'h11, 1'b0));
    send_frame(8'h11, 1'b0, 1'b0);
    exp_q.push_back(mk(8'h22, 1'b1));
    send_frame(8'h22, 1'b0, 1'b0);
    check("t3_overrun", rx_if.overrun, 1);
    check("t3_rx_data", rx_if.rx_data, 8'h22);
    check("t3_hazir", rx_if.data_hazir, 1);
    ack();
    check("t3_ack_clears", rx_if.data_hazir, 0);
    check("t3_overrun_sticky", rx_if.overrun, 1);

    // Chip enable dropped after 3 bits, then a clean frame.
    do_reset();
    fe0 = fe_cycles;
    spi_ce = 1'b0;
    wait_neg(4);
    send_bits(8'hF0, 3);
    spi_ce = 1'b1;
    wait_neg(8);
    check("t4_one_ferr", fe_cycles - fe0, 1);
    check("t4_no_hazir", rx_if.data_hazir, 0);
    check("t4_no_count", rx_if.byte_count, 0);
    exp_q.push_back(mk(8'h5A, 1'b0));
    send_frame(8'h5A, 1'b0, 1'b0);
    check("t4_count", rx_if.byte_count, 1);
    check("t4_rx_data", rx_if.rx_data, 8'h5A);

    // Ack in the same cycle as completion with a byte already pending.
    do_reset();
    exp_q.push_back(mk(8'h42, 1'b0));
    send_frame(8'h42, 1'b0, 1'b0);
    exp_q.push_back(mk(8'h77, 1'b0));
    send_frame(8'h77, 1'b1, 1'b0);
    check("t5_hazir", rx_if.data_hazir, 1);
    check("t5_rx_data", rx_if.rx_data, 8'h77);
    check("t5_overrun", rx_if.overrun, 0);

    // Reset mid-frame, released with chip enable still low.
    do_reset();
    fe0 = fe_cycles;
    spi_ce = 1'b0;
    wait_neg(4);
    send_bits(8'hFF, 5);
    reset = 1'b0;
    wait_neg(2);
    reset = 1'b1;
    send_bits(8'hFF, 3);
    wait_neg(4);
    spi_ce = 1'b1;
    wait_neg(8);
    check("t6_no_hazir", rx_if.data_hazir, 0);
    check("t6_no_ferr", fe_cycles - fe0, 0);
    check("t6_no_count", rx_if.byte_count, 0);
    exp_q.push_back(mk(8'h81, 1'b0));
    send_frame(8'h81, 1'b0, 1'b0);
    check("t6_rx_data", rx_if.rx_data, 8'h81);
    check("t6_count", rx_if.byte_count, 1);

    wait_neg(4);
    check("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
